// File: rtl/hls_loader_pkg.sv
// hls_loader_pkg: shared FSM states, error codes and access size for the HLS memory loader.
package hls_loader_pkg;
    typedef enum logic [3:0] {IDLE, LOAD, WR, START, RUN, DUMP, OUT, DONE, ERR} state_t;
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_RUN  = 2'd1;
    localparam logic [1:0] ERR_MEM  = 2'd2;
    localparam logic [7:0] SIZE_BYTE = 8'd8;
endpackage

// File: rtl/hls_slave_access.sv
// hls_slave_access: one byte access on the core's slave RAM port (channel 0), with a stall watchdog.
module hls_slave_access
    import hls_loader_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int MEM_TO = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              rnw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic              ack,
    output logic [7:0]        rdata,
    output logic              timeout,
    output logic [1:0]        S_oe_ram,
    output logic [1:0]        S_we_ram,
    output logic [ADDR_W-1:0] S_addr_ram,
    output logic [DATA_W-1:0] S_Wdata_ram,
    output logic [7:0]        S_data_ram_size,
    input  logic [DATA_W-1:0] Sout_Rdata_ram,
    input  logic [1:0]        Sout_DataRdy
);
    localparam int TW = $clog2(MEM_TO + 1);

    logic [TW-1:0] timer;
    logic          unused;

    assign unused = ^{Sout_DataRdy[1], Sout_Rdata_ram[DATA_W-1:8]};

    always_comb begin
        ack             = req && Sout_DataRdy[0];
        timeout         = req && !Sout_DataRdy[0] && timer == TW'(MEM_TO - 1);
        rdata           = Sout_Rdata_ram[7:0];
        S_oe_ram        = {1'b0, req && rnw};
        S_we_ram        = {1'b0, req && !rnw};
        S_addr_ram      = req ? addr : '0;
        S_Wdata_ram     = req && !rnw ? DATA_W'(wdata) : '0;
        S_data_ram_size = req ? SIZE_BYTE : 8'd0;
    end

    // timer counts stalled cycles of the current access only
    always_ff @(posedge clock or posedge reset)
        if (reset) timer <= '0;
        else       timer <= req && !Sout_DataRdy[0] ? timer + 1'b1 : '0;
endmodule

// File: rtl/hls_mem_loader.sv
// hls_mem_loader: loads a byte stream into the HLS core RAM, starts the core, times it and streams back a result window.
module hls_mem_loader
    import hls_loader_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 14,
    parameter int TIMEOUT = 200000000,
    parameter int MEM_TO  = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cfg_go,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_load_len,
    input  logic [ADDR_W-1:0] cfg_dump_base,
    input  logic [LEN_W-1:0]  cfg_dump_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [1:0]        S_oe_ram,
    output logic [1:0]        S_we_ram,
    output logic [ADDR_W-1:0] S_addr_ram,
    output logic [DATA_W-1:0] S_Wdata_ram,
    output logic [7:0]        S_data_ram_size,
    input  logic [DATA_W-1:0] Sout_Rdata_ram,
    input  logic [1:0]        Sout_DataRdy,
    output logic              start_port,
    input  logic              done_port,
    output logic              busy,
    output logic              run_done,
    output logic [1:0]        err,
    output logic [31:0]       cycle_count
);
    state_t            state, next;
    logic [ADDR_W-1:0] cur_addr, dump_addr, acc_addr;
    logic [LEN_W-1:0]  load_rem, dump_rem;
    logic [7:0]        wbyte, rbyte, rdata;
    logic [31:0]       cnt, cnt_inc;
    logic              req, rnw, ack, mem_to, run_to;

    assign cnt_inc = &cnt ? cnt : cnt + 32'd1;
    assign run_to  = cnt > 32'(TIMEOUT);

    hls_slave_access #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_TO(MEM_TO)) u_acc (
        .clock(clock), .reset(reset), .req(req), .rnw(rnw), .addr(acc_addr), .wdata(wbyte),
        .ack(ack), .rdata(rdata), .timeout(mem_to),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
    );

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= IDLE;
        else       state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (cfg_go) next = cfg_load_len != '0 ? LOAD : START;
            LOAD:    if (in_valid) next = WR;
            WR:      next = ack ? (load_rem == LEN_W'(1) ? START : LOAD) : mem_to ? ERR : WR;
            START:   next = RUN;
            RUN:     next = done_port ? (dump_rem != '0 ? DUMP : DONE) : run_to ? ERR : RUN;
            DUMP:    next = ack ? OUT : mem_to ? ERR : DUMP;
            OUT:     if (out_ready) next = dump_rem == LEN_W'(1) ? DONE : DUMP;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = state == LOAD;
        out_valid  = state == OUT;
        out_data   = rbyte;
        start_port = state == START;
        busy       = state != IDLE;
        run_done   = state == DONE || state == ERR;
        req        = state == WR || state == DUMP;
        rnw        = state == DUMP;
        acc_addr   = rnw ? dump_addr : cur_addr;
    end

    // cnt holds cycles elapsed since start_port, excluding the current RUN cycle
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            cur_addr    <= '0;
            dump_addr   <= '0;
            load_rem    <= '0;
            dump_rem    <= '0;
            wbyte       <= '0;
            rbyte       <= '0;
            cnt         <= '0;
            err         <= ERR_NONE;
            cycle_count <= '0;
        end else begin
            if (state == IDLE && cfg_go) begin
                cur_addr    <= cfg_base;
                load_rem    <= cfg_load_len;
                dump_addr   <= cfg_dump_base;
                dump_rem    <= cfg_dump_len;
                err         <= ERR_NONE;
                cycle_count <= '0;
            end
            if (state == LOAD && in_valid) wbyte <= in_data;
            if (state == WR && ack) begin
                cur_addr <= cur_addr + 1'b1;
                load_rem <= load_rem - 1'b1;
            end
            if (req && !ack && mem_to) err <= ERR_MEM;
            if (state == START) cnt <= 32'd1;
            if (state == RUN) begin
                cnt <= cnt_inc;
                if (done_port) cycle_count <= cnt_inc;
                else if (run_to) err <= ERR_RUN;
            end
            if (state == DUMP && ack) rbyte <= rdata;
            if (state == OUT && out_ready) begin
                dump_addr <= dump_addr + 1'b1;
                dump_rem  <= dump_rem - 1'b1;
            end
        end
endmodule

// File: tb/tb_hls_mem_loader.sv
// tb_hls_mem_loader: directed bench with a slave RAM model and a core done model for hls_mem_loader.
module tb_hls_mem_loader;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 14;

    logic              clock = 0, reset = 1;
    logic              cfg_go = 0;
    logic [ADDR_W-1:0] cfg_base = 0, cfg_dump_base = 0;
    logic [LEN_W-1:0]  cfg_load_len = 0, cfg_dump_len = 0;
    logic              in_valid = 0, in_ready;
    logic [7:0]        in_data = 0;
    logic              out_valid, out_ready = 0;
    logic [7:0]        out_data;
    logic [1:0]        S_oe_ram, S_we_ram, Sout_DataRdy;
    logic [ADDR_W-1:0] S_addr_ram;
    logic [DATA_W-1:0] S_Wdata_ram, Sout_Rdata_ram;
    logic [7:0]        S_data_ram_size;
    logic              start_port, done_port = 0, busy, run_done;
    logic [1:0]        err;
    logic [31:0]       cycle_count;

    int n_chk = 0, n_pass = 0;

    hls_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(100), .MEM_TO(16)) dut (
        .clock(clock), .reset(reset), .cfg_go(cfg_go), .cfg_base(cfg_base), .cfg_load_len(cfg_load_len),
        .cfg_dump_base(cfg_dump_base), .cfg_dump_len(cfg_dump_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram), .S_Wdata_ram(S_Wdata_ram),
        .S_data_ram_size(S_data_ram_size), .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
        .start_port(start_port), .done_port(done_port), .busy(busy), .run_done(run_done),
        .err(err), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    // slave RAM model: DataRdy after rdy_delay extra cycles, never while stall is set
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    int         rdy_delay = 0, acc_cyc = 0;
    bit         stall = 0;
    logic       active;
    assign active         = S_we_ram[0] || S_oe_ram[0];
    assign Sout_DataRdy   = {1'b0, active && !stall && acc_cyc >= rdy_delay};
    assign Sout_Rdata_ram = {8'h00, mem[S_addr_ram]};
    always @(posedge clock) begin
        acc_cyc <= active && !Sout_DataRdy[0] ? acc_cyc + 1 : 0;
        if (S_we_ram[0] && Sout_DataRdy[0]) mem[S_addr_ram] = S_Wdata_ram[7:0];
    end

    logic [ADDR_W-1:0] wa_q[$];
    logic [7:0]        wd_q[$];
    int                hold_q[$];
    int                we_hold = 0, start_cnt = 0, done_cnt = 0, acc_cnt = 0;
    bit                hold_bad = 0, mutex_bad = 0;
    logic [ADDR_W-1:0] prev_addr = 0;
    logic [DATA_W-1:0] prev_data = 0;
    always @(posedge clock) begin
        if (S_we_ram[0]) begin
            if (we_hold != 0 && (S_addr_ram != prev_addr || S_Wdata_ram != prev_data)) hold_bad <= 1;
            if (Sout_DataRdy[0]) begin
                wa_q.push_back(S_addr_ram);
                wd_q.push_back(S_Wdata_ram[7:0]);
                hold_q.push_back(we_hold + 1);
                we_hold <= 0;
            end else we_hold <= we_hold + 1;
        end else we_hold <= 0;
        prev_addr <= S_addr_ram;
        prev_data <= S_Wdata_ram;
        if (start_port) start_cnt <= start_cnt + 1;
        if (run_done) done_cnt <= done_cnt + 1;
        if (S_we_ram != 0 || S_oe_ram != 0 || S_data_ram_size != 0) acc_cnt <= acc_cnt + 1;
        if (S_we_ram != 0 && S_oe_ram != 0) mutex_bad <= 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic go(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] ll,
                      input logic [ADDR_W-1:0] db, input logic [LEN_W-1:0] dl);
        cfg_base = b; cfg_load_len = ll; cfg_dump_base = db; cfg_dump_len = dl;
        cfg_go = 1;
        @(negedge clock);
        cfg_go = 0;
    endtask

    task automatic feed(input logic [31:0] bytes, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            if (gap) begin in_valid = 0; @(negedge clock); end
            in_valid = 1;
            in_data  = bytes[8*(n-1-i) +: 8];
            while (!in_ready && t < 200) begin @(negedge clock); t++; end
            check("in_ready", 32'(in_ready), 1);
            @(negedge clock);
        end
        in_valid = 0;
    endtask

    task automatic core(input int n, input bit sort);
        int t = 0;
        while (!start_port && t < 1000) begin @(negedge clock); t++; end
        check("start_seen", 32'(start_port), 1);
        if (sort) for (int i = 0; i < 4; i++) mem[16'h100 + i] = 8'(i + 1);
        repeat (n - 1) @(negedge clock);
        done_port = 1;
        @(negedge clock);
        done_port = 0;
    endtask

    task automatic drain(input int n, input bit hold_off, output logic [31:0] got);
        logic [7:0] d0;
        bit         bad;
        got = 0;
        for (int i = 0; i < n; i++) begin
            int t = 0;
            out_ready = 0;
            while (!out_valid && t < 1000) begin @(negedge clock); t++; end
            check("out_valid_wait", 32'(out_valid), 1);
            if (hold_off && i == 0) begin
                d0  = out_data;
                bad = 0;
                repeat (20) begin
                    @(negedge clock);
                    if (out_data != d0 || !out_valid || S_oe_ram != 0 || err != 0) bad = 1;
                end
                check("stall_stable", 32'(bad), 0);
            end
            got = {got[23:0], out_data};
            out_ready = 1;
            @(negedge clock);
            out_ready = 0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 2000) begin @(negedge clock); t++; end
        check("idle_wait", 32'(busy), 0);
    endtask

    int          w0, s0, d0, h0, a0, n;
    logic [31:0] got, pk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        check("rst_ctrl", 32'({busy, run_done, start_port, in_ready, out_valid}), 0);
        check("rst_slave", 32'({S_we_ram, S_oe_ram, S_data_ram_size, S_addr_ram}), 0);
        check("rst_err", 32'(err), 0);
        check("rst_cycle_count", cycle_count, 0);
        reset = 0;
        @(negedge clock);

        // 1: load, sorted result, dump
        w0 = wa_q.size(); s0 = start_cnt; d0 = done_cnt;
        go(14'h100, 4, 14'h100, 4);
        fork
            feed(32'h03010402, 4, 0);
            core(50, 1);
            drain(4, 0, got);
        join
        wait_idle();
        check("t1_wr_count", 32'(wa_q.size() - w0), 4);
        pk = 0;
        for (int i = 0; i < 4; i++) begin
            check("t1_wr_addr", 32'(wa_q[w0+i]), 32'(14'h100 + i));
            pk = {pk[23:0], wd_q[w0+i]};
        end
        check("t1_wr_data", pk, 32'h03010402);
        check("t1_start_pulses", 32'(start_cnt - s0), 1);
        check("t1_cycle_count", cycle_count, 50);
        check("t1_out", got, 32'h01020304);
        check("t1_run_done", 32'(done_cnt - d0), 1);
        check("t1_err", 32'(err), 0);

        // 2: empty load and dump, done right after start
        a0 = acc_cnt; d0 = done_cnt;
        go(0, 0, 0, 0);
        core(2, 0);
        check("t2_run_done_now", 32'(run_done), 1);
        @(negedge clock);
        check("t2_busy_low", 32'(busy), 0);
        check("t2_no_access", 32'(acc_cnt - a0), 0);
        check("t2_cycle_count", cycle_count, 2);
        check("t2_run_done", 32'(done_cnt - d0), 1);

        // 3: slow slave, gappy input
        rdy_delay = 2;
        w0 = wa_q.size(); h0 = hold_q.size();
        go(14'h200, 3, 14'h200, 3);
        fork
            feed(32'h00A55AC3, 3, 1);
            core(5, 0);
            drain(3, 0, got);
        join
        wait_idle();
        rdy_delay = 0;
        check("t3_wr_count", 32'(wa_q.size() - w0), 3);
        pk = 0;
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_cycles", 32'(hold_q[h0+i]), 3);
            pk = {pk[23:0], wd_q[w0+i]};
        end
        check("t3_wr_data", pk, 32'h00A55AC3);
        check("t3_hold_stable", 32'(hold_bad), 0);
        check("t3_out", got, 32'h00A55AC3);

        // 4: core never finishes
        go(0, 0, 0, 0);
        n = 0;
        while (!run_done && n < 500) begin @(negedge clock); n++; end
        check("t4_cycles_to_err", 32'(n), 102);
        check("t4_err", 32'(err), 1);
        check("t4_slave_idle", 32'({S_we_ram, S_oe_ram, S_data_ram_size, S_addr_ram}), 0);
        check("t4_cycle_count", cycle_count, 0);
        @(negedge clock);
        check("t4_busy_low", 32'(busy), 0);

        // 5: consumer stalls 20 cycles
        go(14'h300, 2, 14'h300, 2);
        fork
            feed(32'h00001122, 2, 0);
            core(3, 0);
            drain(2, 1, got);
        join
        wait_idle();
        check("t5_out", got, 32'h00001122);
        check("t5_err", 32'(err), 0);

        // 7: slave never answers
        stall = 1; s0 = start_cnt;
        go(14'h500, 1, 0, 0);
        feed(32'h5A, 1, 0);
        n = 0;
        while (S_we_ram[0] && n < 100) begin n++; @(negedge clock); end
        check("t7_wr_cycles", 32'(n), 16);
        check("t7_run_done", 32'(run_done), 1);
        check("t7_err", 32'(err), 2);
        check("t7_start_none", 32'(start_cnt - s0), 0);
        stall = 0;
        wait_idle();

        // 6: reset in the middle of a write
        rdy_delay = 10;
        go(14'h40, 2, 14'h40, 2);
        in_valid = 1; in_data = 8'h99;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clock); n++; end
        @(negedge clock);
        in_valid = 0;
        check("t6_we_before", 32'(S_we_ram), 1);
        #2 reset = 1;
        #1;
        check("t6_we_async", 32'({S_we_ram, S_data_ram_size}), 0);
        check("t6_busy_async", 32'(busy), 0);
        repeat (2) @(negedge clock);
        reset = 0;
        rdy_delay = 0;
        @(negedge clock);
        check("t6_err_after", 32'(err), 0);
        check("t6_busy_after", 32'(busy), 0);
        w0 = wa_q.size();
        go(14'h40, 1, 14'h40, 1);
        fork
            feed(32'h77, 1, 0);
            core(3, 0);
            drain(1, 0, got);
        join
        wait_idle();
        check("t6_restart_out", got, 32'h77);
        check("t6_restart_wr", 32'({wa_q.size() - w0, wa_q[w0], wd_q[w0]}), 32'({32'd1, 14'h40, 8'h77}));
        check("t6_restart_err", 32'(err), 0);

        check("mutex", 32'(mutex_bad), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/hls_mem_loader.md
Name: hls_mem_loader

Overview:
- Synthesizable front-end that drives the HLS `main` core's slave memory port (S_*_ram) and start/done handshake.
- Sequence per run:
  1. Stream initial-memory bytes in and write them into the core's RAM.
  2. Pulse start_port, then count cycles until done_port.
  3. Read back a result window and stream it out.
- Replaces the file-driven stimulus path so mergesort runs can be executed on hardware.

Parameters:
- ADDR_W, 14, slave address width (matches S_addr_ram)
- DATA_W, 16, slave data width (matches S_Wdata_ram/Sout_Rdata_ram)
- LEN_W, 14, width of byte-count fields
- TIMEOUT, 200000000, max cycles in RUN before error
- MEM_TO, 1024, max cycles waiting on Sout_DataRdy per access before error

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cfg_go  in  1  one-cycle pulse; starts a run; sampled only in IDLE
- cfg_base  in  ADDR_W  byte address of first loaded byte
- cfg_load_len  in  LEN_W  number of bytes to load (0 allowed)
- cfg_dump_base  in  ADDR_W  byte address of first result byte
- cfg_dump_len  in  LEN_W  number of bytes to read back (0 allowed)
- in_valid / in_ready / in_data  in/out/in  1/1/8  load byte stream
- out_valid / out_ready / out_data  out/in/out  1/1/8  result byte stream
- S_oe_ram  out  2  read enable per channel; only bit 0 used, bit 1 tied 0
- S_we_ram  out  2  write enable per channel; only bit 0 used
- S_addr_ram  out  ADDR_W  byte address
- S_Wdata_ram  out  DATA_W  write data, byte in [7:0], upper bits 0
- S_data_ram_size  out  8  access size in bits; 8 when accessing, else 0
- Sout_Rdata_ram  in  DATA_W  read data; byte taken from [7:0]
- Sout_DataRdy  in  2  access-complete per channel; bit 0 used
- start_port  out  1  one-cycle start pulse to core
- done_port  in  1  core completion
- busy  out  1  high in every state except IDLE
- run_done  out  1  one-cycle pulse on DONE or ERR entry
- err  out  2  sticky until next cfg_go: 0 ok, 1 run timeout, 2 memory timeout
- cycle_count  out  32  cycles from start_port to done_port inclusive; held until next cfg_go

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Internal address/length counters and timers 0.
- IDLE:
  - On cfg_go, latch all cfg_* fields, clear err and cycle_count.
  - Go to LOAD if cfg_load_len≠0, else START.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready, capture the byte, drop in_ready, go to WR.
- WR:
  - Hold S_we_ram=2'b01, S_data_ram_size=8, S_addr_ram=cur_addr, S_Wdata_ram={8'h0,byte} until Sout_DataRdy[0].
  - Sout_DataRdy[0] high in the same cycle as assertion completes the access (minimum 1 cycle).
  - On completion: cur_addr+1, remaining-1.
  - Remaining reaches 0 → START; otherwise back to LOAD.
- START:
  - start_port=1 for exactly one cycle; cycle counter set to 1; go to RUN.
- RUN:
  - Counter increments each cycle, saturating at 2^32−1.
  - done_port=1 → latch count into cycle_count; go to DUMP if cfg_dump_len≠0, else DONE.
  - done_port arriving in the same cycle as start_port is ignored.
  - Counter > TIMEOUT → ERR (err=1).
- DUMP:
  - Hold S_oe_ram=2'b01, size 8, addr=dump_addr until Sout_DataRdy[0].
  - Capture Sout_Rdata_ram[7:0] on that cycle; go to OUT.
- OUT:
  - out_valid=1, out_data stable until out_ready.
  - Accepted → addr+1, remaining-1; remaining 0 → DONE, else DUMP.
- DONE:
  - run_done pulse one cycle; return to IDLE.
- ERR:
  - Entered from WR/DUMP after MEM_TO cycles without DataRdy (err=2), or from RUN timeout (err=1).
  - All S_* deasserted, run_done pulse, return to IDLE.
- Addressing: cur_addr wraps modulo 2^ADDR_W; no error on wrap.
- Slave channel mutex: S_we_ram and S_oe_ram are never both nonzero.
- cfg_go while busy is ignored.
- Reset mid-run:
  - Immediately deasserts all S_* and start_port, state IDLE.
  - Bytes in flight are dropped.
  - Any upstream byte already accepted is lost; the source restarts the stream.
- in_ready and out_valid are never high outside LOAD and OUT respectively.

Decomposition:
- Package hls_loader_pkg holds:
  - the state enum (IDLE, LOAD, WR, START, RUN, DUMP, OUT, DONE, ERR)
  - ERR_NONE/ERR_RUN/ERR_MEM constants
  - SIZE_BYTE=8
- Sub-module hls_slave_access: a single-access engine.
  - Inputs: req, rnw, addr, wdata.
  - Drives S_* and returns ack, rdata, timeout using MEM_TO.
  - Shared by WR and DUMP.

Test Plan:
1. Load 4 bytes 0x03,0x01,0x04,0x02 at base 0x100, model core writes sorted result and asserts done after 50 cycles, dump 4 at 0x100.
   → writes at 0x100–0x103 in order; start_port one pulse; cycle_count=50; out stream 01,02,03,04; run_done once; err=0.
2. load_len=0, dump_len=0, done 1 cycle after start.
   → no S_* activity; cycle_count=2; run_done; busy low next cycle.
3. Slave model delays DataRdy 3 cycles per write; in_valid toggles every other cycle.
   → each write held 3 cycles with constant addr/data; no byte lost or duplicated.
4. done_port never asserted, TIMEOUT overridden to 100.
   → ERR after 101 run cycles; err=1; S_* all 0; run_done pulse.
5. out_ready held low 20 cycles during OUT.
   → out_data stable, no new read issued; MEM_TO not triggered.
6. Assert reset during WR with S_we_ram=1.
   → S_we_ram=0 same cycle (async); after release busy=0, err=0; cfg_go restarts cleanly.
